// File: rtl/xaui_rx_deskew.sv
// xaui_rx_deskew: removes inter-lane skew on the 4-lane XAUI rx bus using ||A|| columns, runs LOSS/HUNT/ALIGNED.
// Latency: 1 + tap_i cycles per lane (tap_i = 0..MAX_SKEW-1, learned in HUNT); link_up follows state directly.
// Backpressure: none; one word per mgt_clk in and out, rx_valid qualifies the output word.
// Ports: mgt_rxdata/rxcharisk/codevalid/syncok/rxlock from the MGTs; mgt_enable_align and mgt_enchansync back to them;
//        rx_data/rx_charisk/rx_valid/link_up/code_err_cnt to the 10GbE/XAUI core.
module xaui_rx_deskew #(
  parameter int MAX_SKEW   = 4,
  parameter int ALIGN_LOSS = 4,
  parameter int SYNC_WAIT  = 64
) (
  input  logic        mgt_clk,
  input  logic        reset,
  input  logic [63:0] mgt_rxdata,
  input  logic [7:0]  mgt_rxcharisk,
  input  logic [7:0]  mgt_codevalid,
  input  logic [3:0]  mgt_syncok,
  input  logic [3:0]  mgt_rxlock,
  output logic [3:0]  mgt_enable_align,
  output logic        mgt_enchansync,
  output logic [63:0] rx_data,
  output logic [7:0]  rx_charisk,
  output logic        rx_valid,
  output logic        link_up,
  output logic [15:0] code_err_cnt
);
  localparam int TW = $clog2(MAX_SKEW);
  localparam int SW = (SYNC_WAIT > 1) ? $clog2(SYNC_WAIT) : 1;
  localparam int BW = $clog2(ALIGN_LOSS + 1);
  localparam logic [7:0] K28_3 = 8'h7C;

  typedef enum logic [1:0] {LOSS, HUNT, ALIGNED} state_t;
  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  k;
    logic [1:0]  cv;
  } lane_t;

  state_t        state;
  lane_t         in_lane [4];
  lane_t         dl      [4][MAX_SKEW-1];
  lane_t         dly     [4];
  logic [TW-1:0] tap     [4];
  logic [TW-1:0] off     [4];
  logic [TW-1:0] off_n   [4];
  logic [TW-1:0] w, wn, hmax;
  logic          hunting;
  logic [3:0]    got, got_n;
  logic [SW-1:0] stab_cnt;
  logic [BW-1:0] bad_cnt;
  logic [3:0]    a_in, a_dly;
  logic          b1_in, b1_dly;
  logic [63:0]   dly_data;
  logic [7:0]    dly_k;
  logic [3:0]    n_err;
  logic [16:0]   err_sum;
  logic          link_loss, dup, bad_col, good_col, leave;

  always_comb begin
    a_in     = '0;
    a_dly    = '0;
    b1_in    = 1'b0;
    b1_dly   = 1'b0;
    n_err    = '0;
    dly_data = '0;
    dly_k    = '0;
    for (int i = 0; i < 4; i++) begin
      in_lane[i] = '{d: mgt_rxdata[16*i +: 16], k: mgt_rxcharisk[2*i +: 2], cv: mgt_codevalid[2*i +: 2]};
      // tap 0 bypasses the delay line; tap n reads the n-th stage
      dly[i] = (tap[i] == '0) ? in_lane[i] : dl[i][tap[i] - TW'(1)];
      a_in[i]  = in_lane[i].k[0] && (in_lane[i].d[7:0] == K28_3);
      a_dly[i] = dly[i].k[0] && (dly[i].d[7:0] == K28_3);
      b1_in    = b1_in  | (in_lane[i].k[1] && (in_lane[i].d[15:8] == K28_3));
      b1_dly   = b1_dly | (dly[i].k[1] && (dly[i].d[15:8] == K28_3));
      dly_data[16*i +: 16] = dly[i].d;
      dly_k[2*i +: 2]      = dly[i].k;
      n_err = n_err + {3'b000, ~dly[i].cv[0]} + {3'b000, ~dly[i].cv[1]};
    end
  end

  // Hunt bookkeeping: offsets are window positions at which each lane's A arrived.
  always_comb begin
    link_loss = ~&{mgt_syncok, mgt_rxlock};
    dup       = hunting & |(a_in & got);
    wn        = hunting ? w + TW'(1) : '0;
    got_n     = (hunting ? got : 4'h0) | a_in;
    hmax      = '0;
    for (int i = 0; i < 4; i++) begin
      off_n[i] = (a_in[i] && !(hunting && got[i])) ? wn : off[i];
      if (off_n[i] > hmax) hmax = off_n[i];
    end
    bad_col  = b1_dly | (|a_dly & ~&a_dly);
    good_col = &a_dly & ~b1_dly;
    leave    = link_loss | (bad_col && (bad_cnt == BW'(ALIGN_LOSS - 1)));
    err_sum  = {1'b0, code_err_cnt} + 17'(n_err);
  end

  // Delay lines shift unconditionally so they are full of live data when taps load.
  always_ff @(posedge mgt_clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++)
        for (int k = 0; k < MAX_SKEW - 1; k++) dl[i][k] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        dl[i][0] <= in_lane[i];
        for (int k = 1; k < MAX_SKEW - 1; k++) dl[i][k] <= dl[i][k-1];
      end
    end
  end

  always_ff @(posedge mgt_clk) begin
    if (reset) begin
      state        <= LOSS;
      stab_cnt     <= '0;
      hunting      <= 1'b0;
      w            <= '0;
      got          <= '0;
      bad_cnt      <= '0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      rx_charisk   <= '0;
      code_err_cnt <= '0;
      for (int i = 0; i < 4; i++) begin
        off[i] <= '0;
        tap[i] <= '0;
      end
    end else begin
      if (state == ALIGNED && !leave) begin
        rx_valid   <= 1'b1;
        rx_data    <= dly_data;
        rx_charisk <= dly_k;
      end else begin
        rx_valid   <= 1'b0;
        rx_data    <= '0;
        rx_charisk <= '0;
      end
      if (state == ALIGNED) code_err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];

      if (link_loss) begin
        state    <= LOSS;
        stab_cnt <= '0;
        hunting  <= 1'b0;
        got      <= '0;
      end else begin
        case (state)
          LOSS: begin
            if (stab_cnt == SW'(SYNC_WAIT - 1)) begin
              state    <= HUNT;
              stab_cnt <= '0;
            end else begin
              stab_cnt <= stab_cnt + SW'(1);
            end
          end
          HUNT: begin
            if (b1_in || dup) begin
              hunting <= 1'b0;
              got     <= '0;
            end else if (hunting || |a_in) begin
              if (&got_n) begin
                for (int i = 0; i < 4; i++) tap[i] <= hmax - off_n[i];
                state   <= ALIGNED;
                hunting <= 1'b0;
                got     <= '0;
                bad_cnt <= '0;
              end else if (hunting && wn == TW'(MAX_SKEW - 1)) begin
                hunting <= 1'b0;
                got     <= '0;
              end else begin
                hunting <= 1'b1;
                got     <= got_n;
                w       <= wn;
                for (int i = 0; i < 4; i++) off[i] <= off_n[i];
              end
            end
          end
          ALIGNED: begin
            if (bad_col) begin
              if (bad_cnt == BW'(ALIGN_LOSS - 1)) begin
                state   <= HUNT;
                bad_cnt <= '0;
              end else begin
                bad_cnt <= bad_cnt + BW'(1);
              end
            end else if (good_col) begin
              bad_cnt <= '0;
            end
          end
          default: state <= LOSS;
        endcase
      end
    end
  end

  assign link_up          = (state == ALIGNED);
  assign mgt_enable_align = link_up ? 4'h0 : 4'hF;
  assign mgt_enchansync   = 1'b0;

endmodule

// File: tb/tb_xaui_rx_deskew.sv
// tb_xaui_rx_deskew: directed vectors for xaui_rx_deskew with hand-derived expectations.
// Latency: expected rx_data is rebuilt from a history of driven words and per-lane expected taps.
// Backpressure: none; one word is driven per clock.
module tb_xaui_rx_deskew;
  logic        mgt_clk = 1'b0;
  logic        reset;
  logic [63:0] mgt_rxdata;
  logic [7:0]  mgt_rxcharisk;
  logic [7:0]  mgt_codevalid;
  logic [3:0]  mgt_syncok;
  logic [3:0]  mgt_rxlock;
  logic [3:0]  mgt_enable_align;
  logic        mgt_enchansync;
  logic [63:0] rx_data;
  logic [7:0]  rx_charisk;
  logic        rx_valid;
  logic        link_up;
  logic [15:0] code_err_cnt;

  xaui_rx_deskew dut (
    .mgt_clk          (mgt_clk),
    .reset            (reset),
    .mgt_rxdata       (mgt_rxdata),
    .mgt_rxcharisk    (mgt_rxcharisk),
    .mgt_codevalid    (mgt_codevalid),
    .mgt_syncok       (mgt_syncok),
    .mgt_rxlock       (mgt_rxlock),
    .mgt_enable_align (mgt_enable_align),
    .mgt_enchansync   (mgt_enchansync),
    .rx_data          (rx_data),
    .rx_charisk       (rx_charisk),
    .rx_valid         (rx_valid),
    .link_up          (link_up),
    .code_err_cnt     (code_err_cnt)
  );

  always #5 mgt_clk = ~mgt_clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          gs = 0;
  logic [3:0]  syncok = 4'hF;
  logic [63:0] hist_d [16384];
  logic [7:0]  hist_k [16384];
  int          exp_tap [4];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Lanes in amask carry ||A|| (K28.3 in byte0); others carry non-K data never equal to 7C.
  task automatic step(input logic [3:0] amask, input logic [7:0] cv);
    logic [63:0] d;
    logic [7:0]  k;
    logic [5:0]  s;
    s = gs[5:0];
    for (int i = 0; i < 4; i++) begin
      if (amask[i]) begin
        d[16*i +: 16] = {2'b00, s, 8'h7C};
        k[2*i +: 2]   = 2'b01;
      end else begin
        d[16*i +: 16] = {4'(i + 1), 4'h0, 2'b00, s};
        k[2*i +: 2]   = 2'b00;
      end
    end
    mgt_rxdata    = d;
    mgt_rxcharisk = k;
    mgt_codevalid = cv;
    mgt_syncok    = syncok;
    hist_d[gs]    = d;
    hist_k[gs]    = k;
    @(posedge mgt_clk);
    #1;
    gs++;
  endtask

  task automatic check_data(input string tag);
    logic [63:0] ed;
    logic [7:0]  ek;
    for (int i = 0; i < 4; i++) begin
      ed[16*i +: 16] = hist_d[gs - 1 - exp_tap[i]][16*i +: 16];
      ek[2*i +: 2]   = hist_k[gs - 1 - exp_tap[i]][2*i +: 2];
    end
    check_val({tag, "_data"}, rx_data, ed);
    check_val({tag, "_k"}, 64'(rx_charisk), 64'(ek));
  endtask

  task automatic check_down(input string tag);
    check_val({tag, "_link"}, 64'(link_up), 64'd0);
    check_val({tag, "_valid"}, 64'(rx_valid), 64'd0);
    check_val({tag, "_data"}, rx_data, 64'd0);
    check_val({tag, "_k"}, 64'(rx_charisk), 64'd0);
    check_val({tag, "_ena"}, 64'(mgt_enable_align), 64'hF);
  endtask

  initial begin
    reset         = 1'b1;
    mgt_rxlock    = 4'hF;
    mgt_syncok    = 4'hF;
    mgt_rxdata    = '0;
    mgt_rxcharisk = '0;
    mgt_codevalid = 8'hFF;
    for (int j = 0; j < 3; j++) step(4'h0, 8'hFF);
    check_down("rst");
    check_val("rst_errcnt", 64'(code_err_cnt), 64'd0);
    check_val("rst_chansync", 64'(mgt_enchansync), 64'd0);

    // LOSS -> HUNT exactly 64 cycles after status is high: an A column on
    // cycle 64 is still seen in LOSS, the one on cycle 65 completes the hunt.
    reset = 1'b0;
    for (int j = 1; j <= 63; j++) begin
      step(4'h0, 8'hFF);
      check_val("loss_link", 64'(link_up), 64'd0);
    end
    step(4'hF, 8'hFF);
    check_val("loss_a64_link", 64'(link_up), 64'd0);
    step(4'hF, 8'hFF);
    check_val("hunt_a65_link", 64'(link_up), 64'd1);
    check_val("hunt_a65_valid", 64'(rx_valid), 64'd0);
    check_val("aligned_ena", 64'(mgt_enable_align), 64'd0);

    // Zero skew: output is the input of the same clock edge (1-cycle latency).
    exp_tap = '{0, 0, 0, 0};
    for (int j = 0; j < 40; j++) begin
      step((j % 16 == 15) ? 4'hF : 4'h0, 8'hFF);
      check_val("zs_valid", 64'(rx_valid), 64'd1);
      check_val("zs_link", 64'(link_up), 64'd1);
      check_data("zs");
    end

    // 3 bad columns, then a good one resets the count: link stays up.
    for (int r = 0; r < 3; r++) begin
      step(4'b1110, 8'hFF);
      step(4'h0, 8'hFF);
      step(4'h0, 8'hFF);
    end
    step(4'hF, 8'hFF);
    check_val("bad3_link", 64'(link_up), 64'd1);
    step(4'h0, 8'hFF);
    step(4'h0, 8'hFF);
    // 4 consecutive bad columns: HUNT on the 4th.
    for (int r = 0; r < 4; r++) begin
      step(4'b1110, 8'hFF);
      if (r < 3) begin
        check_val("bad4_link_hold", 64'(link_up), 64'd1);
        step(4'h0, 8'hFF);
      end else begin
        check_down("bad4");
      end
    end

    // Lane 2 A arrives 3 words after lanes 0/1/3: taps {3,3,0,3}.
    for (int j = 0; j < 3; j++) step(4'h0, 8'hFF);
    step(4'b1011, 8'hFF);
    step(4'h0, 8'hFF);
    step(4'h0, 8'hFF);
    step(4'b0100, 8'hFF);
    check_val("skew_align_link", 64'(link_up), 64'd1);
    check_val("skew_align_ena", 64'(mgt_enable_align), 64'd0);
    exp_tap = '{3, 3, 0, 3};
    for (int j = 0; j < 32; j++) begin
      int m;
      m = (j + 4) % 16;
      step((m == 0) ? 4'b1011 : (m == 3) ? 4'b0100 : 4'h0, 8'hFF);
      check_val("skew_valid", 64'(rx_valid), 64'd1);
      check_val("skew_link", 64'(link_up), 64'd1);
      check_data("skew");
      if (m == 3)
        check_val("skew_col", 64'({rx_data[55:48], rx_data[39:32], rx_data[23:16], rx_data[7:0]}),
                  64'h7C7C7C7C);
    end

    // One-cycle syncok[3] drop forces LOSS immediately.
    syncok = 4'b0111;
    step(4'h0, 8'hFF);
    syncok = 4'hF;
    check_down("syncdrop");

    // Back to HUNT, then lane 1 arrives 4 words late: never aligns.
    for (int j = 0; j < 64; j++) step(4'h0, 8'hFF);
    for (int p = 0; p < 3; p++) begin
      for (int m = 0; m < 16; m++) begin
        step((m == 0) ? 4'b1101 : (m == 4) ? 4'b0010 : 4'h0, 8'hFF);
        check_val("late4_link", 64'(link_up), 64'd0);
        check_val("late4_valid", 64'(rx_valid), 64'd0);
      end
    end

    // Re-align with zero skew, then code error counting and saturation.
    step(4'hF, 8'hFF);
    check_val("realign_link", 64'(link_up), 64'd1);
    check_val("err_start", 64'(code_err_cnt), 64'd0);
    step(4'h0, 8'hE0);
    check_val("err_five", 64'(code_err_cnt), 64'd5);
    check_val("err_five_valid", 64'(rx_valid), 64'd1);
    for (int j = 0; j < 8191; j++) step(4'h0, 8'h00);
    step(4'h0, 8'hFE);
    check_val("err_fffe", 64'(code_err_cnt), 64'hFFFE);
    step(4'h0, 8'hFC);
    check_val("err_sat", 64'(code_err_cnt), 64'hFFFF);
    step(4'h0, 8'h00);
    check_val("err_sat_hold", 64'(code_err_cnt), 64'hFFFF);
    check_val("err_link", 64'(link_up), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
